data_mem_sys: RTL and testbench
===============================

DATA_MEM_SYS -- requirements
Module: data_mem_sys

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port: m_data_addr  input  32  byte address from the CPU memory stage.
REQ-004 SHALL have port: m_data_wdata  input  32  write data, already lane-aligned by the CPU.
REQ-005 SHALL have port: m_data_byteen  input  4  byte write enables; bit i writes bits [8i+7:8i]; 4'b0000 = no write.
REQ-006 SHALL have port: m_data_rdata  output  32  read data for the word at m_data_addr[31:2].
REQ-007 SHALL have port: irq  output  1  timer interrupt request, level.
REQ-008 SHALL have parameter: DM_WORDS, default 3072, data-memory depth in words.

Function
REQ-009 SHALL decode as follows: DM = 0x0000_0000..0x0000_2FFF; TC = 0x0000_7F00..0x0000_7F0B, where 0x7F00 is CTRL, 0x7F04 is PRESET and 0x7F08 is COUNT; all other addresses are unmapped.
REQ-010 SHALL ignore m_data_addr[1:0] for decode and data access.
REQ-011 SHALL drive m_data_rdata combinationally in the same cycle as m_data_addr, with zero-cycle read latency, because the CPU consumes it in its memory stage.
REQ-012 SHALL return 0 on m_data_rdata for unmapped reads, and SHALL silently drop writes to unmapped addresses.
REQ-013 SHALL commit DM writes at the rising edge, updating only the byte lanes enabled in m_data_byteen.
REQ-014 SHALL make a read in the cycle after a write return the new data; a same-cycle read returns the old data.
REQ-015 SHALL implement CTRL bits as: [0] EN; [2:1] MODE (00 = one-shot, 01 = auto-reload, other values behave as 00); [3] IM (interrupt mask); bits [31:4] read 0.
REQ-016 SHALL write CTRL and PRESET with byte-lane granularity, and SHALL ignore writes to COUNT.
REQ-017 SHALL implement the timer FSM states IDLE, LOAD, CNT and INT, each held for at least one cycle.
REQ-018 SHALL transition IDLE -> LOAD when EN=1.
REQ-019 SHALL, in LOAD, set COUNT <= PRESET and move to CNT.
REQ-020 SHALL, in CNT, go to IDLE if EN=0 (COUNT holds); otherwise decrement COUNT if COUNT>1; otherwise set COUNT <= 0 and go to INT.
REQ-021 SHALL handle PRESET=0 or PRESET=1 by reaching INT one cycle after LOAD.
REQ-022 SHALL, in INT with MODE 00, set irq_flag, clear EN and go to IDLE.
REQ-023 SHALL, in INT with MODE 01, assert irq_flag for exactly that one cycle and go to IDLE, which then reloads because EN remains 1.
REQ-024 SHALL, in MODE 00, hold irq_flag until any CPU write to CTRL or PRESET, which clears it.
REQ-025 SHALL drive irq = irq_flag AND IM, registered with no combinational path from the inputs.
REQ-026 SHALL let a CPU CTRL write win over an FSM EN clear when both occur in the same cycle.
REQ-027 SHALL make a PRESET write during CNT take effect only at the next LOAD.
REQ-028 SHALL keep COUNT wrap-free, since it never decrements below 0.

Reset
REQ-029 SHALL, on reset, clear CTRL, PRESET, COUNT and irq_flag to 0, set the FSM to IDLE and drive irq=0.
REQ-030 SHALL, on reset, clear all DM words to 0.
REQ-031 SHALL let reset override any same-cycle write.
REQ-032 SHALL, on reset mid-count, abort the count with no irq generated.

Structure
REQ-033 SHALL place address bases and limits, register offsets, CTRL bit positions, MODE codes and FSM state encodings in the shared macro package used by the pipeline.
REQ-034 SHALL implement the timer as sub-module tc_timer (clk, reset, addr[3:2], we, byteen, wdata, rdata, irq); data_mem_sys holds the DM array and the decode/read mux.

Verification
REQ-035 SHALL cover a byte-lane write: sw 0x11223344 @0x10, then byteen=0100 with wdata=0x00AA0000 @0x10 -> read @0x10 returns 0x11AA3344.
REQ-036 SHALL cover unmapped access: write 0xDEADBEEF @0x4000 -> no state change; read @0x4000 returns 0.
REQ-037 SHALL cover one-shot mode: PRESET=3, then CTRL=0x9 -> COUNT reads 3,2,1,0 on consecutive cycles after LOAD; irq rises the cycle after INT and stays high; CTRL EN reads 0; a CTRL write clears irq.
REQ-038 SHALL cover auto-reload: PRESET=2, CTRL=0xB -> irq is a 1-cycle pulse every 5 cycles (LOAD, CNT×2, INT, IDLE) across 3 periods.
REQ-039 SHALL cover the simultaneous event: CTRL=0x1 written in the same cycle the FSM is in INT with MODE 00 -> EN reads 1 and the next LOAD occurs.
REQ-040 SHALL cover reset mid-count: PRESET=100, run 10 cycles, assert reset -> COUNT=0, state IDLE, irq=0, and DM reads 0.

Source files
------------

// File: rtl/data_mem_sys_pkg.sv
// Shared memory-map, timer register and FSM definitions for the data-memory system.
package data_mem_sys_pkg;

  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT = 32'h0000_2FFF;
  localparam logic [31:0] TC_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TC_LIMIT = 32'h0000_7F0B;

  // Timer register select, taken from addr[3:2]
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {TC_IDLE, TC_LOAD, TC_CNT, TC_INT} tc_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/data_mem_sys_tc_timer.sv
// Memory-mapped down-counting timer (CTRL / PRESET / COUNT) with level irq.
module tc_timer
  import data_mem_sys_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  tc_state_e   state_q, state_d;

  logic en, auto_mode, ctrl_wr, preset_wr;

  assign en        = ctrl_q[CTRL_EN];
  assign auto_mode = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);
  assign ctrl_wr   = we && (addr == TC_CTRL)   && (|byteen);
  assign preset_wr = we && (addr == TC_PRESET) && (|byteen);

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    // Auto-reload flag lives for only the single cycle after INT
    irq_flag_d = auto_mode ? 1'b0 : irq_flag_q;

    case (state_q)
      TC_IDLE: if (en) state_d = TC_LOAD;
      TC_LOAD: begin
        count_d = preset_q;
        state_d = TC_CNT;
      end
      TC_CNT: begin
        if (!en)                state_d = TC_IDLE;
        else if (count_q > 32'd1) count_d = count_q - 32'd1;
        else begin
          count_d = '0;
          state_d = TC_INT;
        end
      end
      TC_INT: begin
        irq_flag_d = 1'b1;
        if (!auto_mode) ctrl_d[CTRL_EN] = 1'b0;
        state_d = TC_IDLE;
      end
      default: state_d = TC_IDLE;
    endcase

    // CPU writes come last so they win over the FSM's EN clear
    if (ctrl_wr && byteen[0]) ctrl_d   = wdata[3:0];
    if (preset_wr)            preset_d = byte_merge(preset_q, wdata, byteen);
    if ((ctrl_wr || preset_wr) && state_q != TC_INT) irq_flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= TC_IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    case (addr)
      TC_CTRL:   rdata = {28'd0, ctrl_q};
      TC_PRESET: rdata = preset_q;
      TC_COUNT:  rdata = count_q;
      default:   rdata = '0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: rtl/data_mem_sys.sv
// Data memory plus timer behind a zero-latency CPU load/store port.
module data_mem_sys
  import data_mem_sys_pkg::*;
#(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        irq
);

  localparam int AW = $clog2(DM_WORDS);

  logic [31:0]   dm_q [DM_WORDS];
  logic [31:0]   word_addr, dm_off, tc_rdata;
  logic [AW-1:0] dm_idx;
  logic          dm_sel, tc_sel, dm_we;
  logic          unused_ok;

  assign unused_ok = &{1'b0, m_data_addr[1:0]};
  assign word_addr = {m_data_addr[31:2], 2'b00};
  assign dm_off    = word_addr - DM_BASE;
  assign dm_sel    = (dm_off <= (DM_LIMIT - DM_BASE)) && (dm_off[31:2] < 30'(DM_WORDS));
  assign tc_sel    = (word_addr >= TC_BASE) && (word_addr <= TC_LIMIT);
  assign dm_idx    = dm_off[AW+1:2];
  assign dm_we     = dm_sel && (|m_data_byteen);

  for (genvar w = 0; w < DM_WORDS; w++) begin : g_dm
    always_ff @(posedge clk) begin
      if (reset)
        dm_q[w] <= '0;
      else if (dm_we && dm_idx == AW'(w))
        dm_q[w] <= byte_merge(dm_q[w], m_data_wdata, m_data_byteen);
    end
  end

  tc_timer u_tc (
    .clk    (clk),
    .reset  (reset),
    .addr   (m_data_addr[3:2]),
    .we     (tc_sel),
    .byteen (m_data_byteen),
    .wdata  (m_data_wdata),
    .rdata  (tc_rdata),
    .irq    (irq)
  );

  always_comb begin
    if (dm_sel)      m_data_rdata = dm_q[dm_idx];
    else if (tc_sel) m_data_rdata = tc_rdata;
    else             m_data_rdata = '0;
  end

endmodule

// File: tb/tb_data_mem_sys.sv
// Directed bench for data_mem_sys: DM byte lanes, decode, timer modes, reset.
module tb_data_mem_sys;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;
  logic        irq;
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [31:0] A_CTRL = 32'h7F00, A_PRE = 32'h7F04, A_CNT = 32'h7F08;

  data_mem_sys dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    step();
    m_data_byteen = 4'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    m_data_addr = a;
    #1;
    chk(tag, m_data_rdata, exp);
  endtask

  task automatic do_reset();
    m_data_byteen = 4'h0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    m_data_addr = '0; m_data_wdata = '0; m_data_byteen = '0; reset = 1'b0;
    #1;
    do_reset();

    // reset state
    rd_chk("rst_dm0", 32'h0, 32'h0);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_count", A_CNT, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);

    // byte-lane write, same-cycle read returns old data
    wr(32'h10, 32'h1122_3344, 4'hF);
    rd_chk("sw_full", 32'h10, 32'h1122_3344);
    m_data_wdata  = 32'h00AA_0000;
    m_data_byteen = 4'b0100;
    #1;
    chk("same_cycle_old", m_data_rdata, 32'h1122_3344);
    step();
    m_data_byteen = 4'h0;
    rd_chk("byte_lane", 32'h10, 32'h11AA_3344);
    rd_chk("addr_lsb_ignored", 32'h13, 32'h11AA_3344);

    // unmapped accesses and DM boundary
    wr(32'h4000, 32'hDEAD_BEEF, 4'hF);
    rd_chk("unmapped_rd", 32'h4000, 32'h0);
    rd_chk("unmapped_no_side", 32'h10, 32'h11AA_3344);
    wr(32'h2FFC, 32'hA5A5_5A5A, 4'hF);
    wr(32'h3000, 32'hFFFF_FFFF, 4'hF);
    rd_chk("dm_top", 32'h2FFC, 32'hA5A5_5A5A);
    rd_chk("dm_past_top", 32'h3000, 32'h0);
    wr(32'h7F0C, 32'h1234_5678, 4'hF);
    rd_chk("tc_past_top", 32'h7F0C, 32'h0);
    wr(A_CNT, 32'h55, 4'hF);
    rd_chk("count_ro", A_CNT, 32'h0);

    // one-shot: PRESET=3, CTRL=EN|IM
    wr(A_PRE, 32'd3, 4'hF);
    rd_chk("preset_rd", A_PRE, 32'd3);
    wr(A_CTRL, 32'h9, 4'hF);
    m_data_addr = A_CNT;
    step();
    step(); chk("os_cnt3", m_data_rdata, 32'd3);
    step(); chk("os_cnt2", m_data_rdata, 32'd2);
    step(); chk("os_cnt1", m_data_rdata, 32'd1);
    step(); chk("os_cnt0", m_data_rdata, 32'd0);
    chk("os_irq_in_int", {31'd0, irq}, 32'h0);
    step(); chk("os_irq_rise", {31'd0, irq}, 32'h1);
    step(); chk("os_irq_hold", {31'd0, irq}, 32'h1);
    rd_chk("os_en_clr", A_CTRL, 32'h8);
    wr(A_CTRL, 32'h8, 4'h1);
    chk("os_irq_clr", {31'd0, irq}, 32'h0);

    // auto-reload: PRESET=2, CTRL=EN|AUTO|IM, pulse every 5 cycles
    wr(A_PRE, 32'd2, 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("ar_irq_c%0d", k), {31'd0, irq}, {31'd0, (k % 5) == 0});
    end

    // CPU CTRL write coincides with one-shot INT
    do_reset();
    wr(A_PRE, 32'd1, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    m_data_addr = A_CNT;
    step();
    step(); chk("sim_cnt1", m_data_rdata, 32'd1);
    step(); chk("sim_int_cnt0", m_data_rdata, 32'd0);
    wr(A_CTRL, 32'h1, 4'h1);
    rd_chk("sim_en_kept", A_CTRL, 32'h1);
    m_data_addr = A_CNT;
    step(); chk("sim_load", m_data_rdata, 32'd0);
    step(); chk("sim_reload", m_data_rdata, 32'd1);

    // PRESET write mid-count, then reset mid-count with a colliding write
    do_reset();
    wr(32'h20, 32'hCAFE_F00D, 4'hF);
    rd_chk("rm_dm_pre", 32'h20, 32'hCAFE_F00D);
    wr(A_PRE, 32'd100, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    m_data_addr = A_CNT;
    repeat (10) step();
    chk("rm_cnt92", m_data_rdata, 32'd92);
    wr(A_PRE, 32'd5, 4'hF);
    rd_chk("rm_preset_deferred", A_CNT, 32'd91);
    m_data_addr   = 32'h24;
    m_data_wdata  = 32'h1234_5678;
    m_data_byteen = 4'hF;
    reset = 1'b1;
    step();
    m_data_byteen = 4'h0;
    step();
    reset = 1'b0;
    rd_chk("rm_dm_clr", 32'h20, 32'h0);
    rd_chk("rm_rst_wins", 32'h24, 32'h0);
    rd_chk("rm_ctrl", A_CTRL, 32'h0);
    rd_chk("rm_preset", A_PRE, 32'h0);
    m_data_addr = A_CNT;
    repeat (5) step();
    chk("rm_cnt_idle", m_data_rdata, 32'h0);
    chk("rm_irq", {31'd0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
